cpu_data_display: RTL and testbench

Eight-digit multiplexed hexadecimal seven-segment driver that consumes the 32-bit `Output_Data` word produced by the `CPU_R_I` core and shows it on the board display. It captures the CPU result into a shadow register on a load strobe and scans one digit per prescaler period. It can freeze the shown value and blank leading zeros. It sits directly downstream of `CPU_R_I` in the board top level.

---
 rtl/cpu_data_display_if.sv | 16 +
 rtl/cpu_data_display.sv | 89 ++++++++
 tb/tb_cpu_data_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_data_display_if.sv
// Bus between the CPU result path and the seven-segment display driver.
// The master drives the capture controls; the slave drives the display pins.
interface cpu_data_display_if;
  logic [31:0] data_in;
  logic        load;
  logic        hold;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        changed;

  modport master (output data_in, load, hold, blank_lz,
                  input  an, seg, changed);
  modport slave  (input  data_in, load, hold, blank_lz,
                  output an, seg, changed);
endinterface

// File: rtl/cpu_data_display.sv
// Eight-digit multiplexed hex display driver for the CPU result word.
// Captures into a shadow register, scans one digit per prescaler period, optional leading-zero blanking.
module cpu_data_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_data_display_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          cap_diff;
  logic          capture;
  logic [3:0]    nib;
  logic [2:0]    top;
  logic          blank;
  logic [6:0]    seg_dec;

  assign capture = bus.load && !bus.hold;

  // Down-counter reloads at terminal count, so each digit lasts exactly SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= CNT_TOP;
      idx         <= '0;
      shadow      <= '0;
      cap_diff    <= 1'b0;
      bus.an      <= 8'hFF;
      bus.seg     <= 7'h7F;
      bus.changed <= 1'b0;
    end else begin
      if (cnt == '0) begin
        cnt <= CNT_TOP;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (capture) shadow <= bus.data_in;
      // Two-stage so the pulse lines up with the first display of the new value.
      cap_diff    <= capture && (bus.data_in != shadow);
      bus.changed <= cap_diff;
      if (blank) begin
        bus.an  <= 8'hFF;
        bus.seg <= 7'h7F;
      end else begin
        bus.an  <= ~(8'b1 << idx);
        bus.seg <= seg_dec;
      end
    end
  end

  always_comb begin
    nib = shadow[4*idx +: 4];
    top = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (shadow[4*k +: 4] != 4'h0) top = 3'(k);
    end
    blank = bus.blank_lz && (idx > top);
  end

  always_comb begin
    seg_dec = 7'h7F;
    case (nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_cpu_data_display.sv
// Scoreboard bench for cpu_data_display: three instances (SCAN_DIV 4, 1, 3) share one stimulus.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares them.
module tb_cpu_data_display;

  typedef struct {
    int         cyc;
    int         dut;
    bit         chk_disp;
    bit         chk_chg;
    logic [7:0] an;
    logic [6:0] seg;
    logic       chg;
    string      name;
  } exp_t;

  typedef logic [6:0] seg_arr_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        load, hold, blank_lz;
  int          cyc = 0;
  int          rl = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  cpu_data_display_if b4 ();
  cpu_data_display_if b1 ();
  cpu_data_display_if b3 ();

  assign b4.data_in = data_in;  assign b4.load = load;  assign b4.hold = hold;  assign b4.blank_lz = blank_lz;
  assign b1.data_in = data_in;  assign b1.load = load;  assign b1.hold = hold;  assign b1.blank_lz = blank_lz;
  assign b3.data_in = data_in;  assign b3.load = load;  assign b3.hold = hold;  assign b3.blank_lz = blank_lz;

  cpu_data_display #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  cpu_data_display #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  cpu_data_display #(.SCAN_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int d, bit cd, bit cc, logic [7:0] a, logic [6:0] s,
                               logic ch, string n);
    exp_t e;
    e.cyc = c; e.dut = d; e.chk_disp = cd; e.chk_chg = cc;
    e.an = a; e.seg = s; e.chg = ch; e.name = n;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation due at this cycle against the chosen instance.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] a;
    logic [6:0] s;
    logic       ch;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin a = b4.an; s = b4.seg; ch = b4.changed; end
        1:       begin a = b1.an; s = b1.seg; ch = b1.changed; end
        default: begin a = b3.an; s = b3.seg; ch = b3.changed; end
      endcase
      if (e.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL %s late expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else begin
        if (e.chk_disp) begin
          checks++;
          if (a !== e.an) begin
            errors++;
            $display("FAIL %s an cyc=%0d dut=%0d got=%h exp=%h", e.name, cyc, e.dut, a, e.an);
          end
          checks++;
          if (s !== e.seg) begin
            errors++;
            $display("FAIL %s seg cyc=%0d dut=%0d got=%h exp=%h", e.name, cyc, e.dut, s, e.seg);
          end
        end
        if (e.chk_chg) begin
          checks++;
          if (ch !== e.chg) begin
            errors++;
            $display("FAIL %s changed cyc=%0d dut=%0d got=%b exp=%b", e.name, cyc, e.dut, ch, e.chg);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load on the SCAN_DIV=1 instance and expect one full frame of the new value.
  task automatic do_load(input logic [31:0] d, input logic hv, input logic exp_chg,
                         input seg_arr_t s, input logic [7:0] bmask, input string n);
    int         c;
    int         dg;
    logic [7:0] a;
    c = cyc;
    data_in = d; load = 1'b1; hold = hv;
    push(c + 1, 1, 1'b0, 1'b1, 8'h00, 7'h00, 1'b0, n);
    for (int e = c + 2; e <= c + 9; e++) begin
      dg = (e - 1 - rl) % 8;
      a = 8'd1 << dg;
      if (bmask[dg]) push(e, 1, 1'b1, 1'b1, 8'hFF, 7'h7F, (e == c + 2) ? exp_chg : 1'b0, n);
      else           push(e, 1, 1'b1, 1'b1, ~a, s[dg], (e == c + 2) ? exp_chg : 1'b0, n);
    end
    tick();
    load = 1'b0; hold = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int         w;
    int         x;
    logic [7:0] a;
    seg_arr_t   s_1234 = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    rst_n = 1'b0; load = 1'b0; hold = 1'b0; blank_lz = 1'b0; data_in = '0;
    for (int d = 0; d < 3; d++) push(2, d, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b0, "reset");
    repeat (3) tick();
    rst_n = 1'b1;
    rl = 3;

    // Idle scan on SCAN_DIV=4: each enable held 4 cycles, one full frame plus wrap.
    for (int i = 0; i < 36; i++) begin
      a = 8'd1 << ((i / 4) % 8);
      push(cyc + 1 + i, 0, 1'b1, 1'b1, ~a, 7'h40, 1'b0, "idle_scan");
    end
    repeat (36) tick();

    do_load(32'h89AB_CDEF, 1'b0, 1'b1,
            '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'h00, "load_hex");

    blank_lz = 1'b1;
    do_load(32'h0000_0A05, 1'b0, 1'b1,
            '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hF8, "blank_a05");
    do_load(32'h0000_0000, 1'b0, 1'b1,
            '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFE, "blank_zero");

    do_load(32'h1234_5678, 1'b0, 1'b1, s_1234, 8'h00, "load_1234");
    do_load(32'hFFFF_FFFF, 1'b1, 1'b0, s_1234, 8'h00, "hold_load");
    do_load(32'h1234_5678, 1'b0, 1'b0, s_1234, 8'h00, "reload_same");

    // Capture on the digit 0 -> 1 wrap edge of the SCAN_DIV=3 instance.
    w = rl + 3;
    while (w <= cyc + 1) w += 24;
    while (cyc < w - 1) tick();
    data_in = 32'h0000_00F0; load = 1'b1;
    push(w,     2, 1'b1, 1'b1, 8'hFE, 7'h00, 1'b0, "wrap_before");
    push(w + 1, 2, 1'b1, 1'b1, 8'hFD, 7'h0E, 1'b1, "wrap_load");
    push(w + 2, 2, 1'b1, 1'b1, 8'hFD, 7'h0E, 1'b0, "wrap_hold_digit");
    tick();
    load = 1'b0;
    repeat (3) tick();

    // Mid-scan reset while the SCAN_DIV=1 instance displays digit 5.
    blank_lz = 1'b0;
    tick(); tick();
    x = cyc + 2;
    while (((x - 2 - rl) % 8) != 5) x++;
    push(x - 1, 1, 1'b1, 1'b1, 8'hDF, 7'h40, 1'b0, "pre_reset_d5");
    push(x,     1, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b0, "mid_reset");
    push(x + 1, 1, 1'b1, 1'b1, 8'hFE, 7'h40, 1'b0, "restart_d0");
    push(x + 2, 1, 1'b1, 1'b1, 8'hFD, 7'h40, 1'b0, "restart_d1_cleared");
    push(x + 3, 1, 1'b1, 1'b1, 8'hFB, 7'h40, 1'b0, "restart_d2");
    while (cyc < x - 1) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rl = x;
    repeat (5) tick();

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
